// File: rtl/hill_cipher_decrypt.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | hill_cipher_decrypt : P = K^-1 * C (mod 26) for one 3-letter block,      |
// | inverting the key on the fly and emitting uppercase ASCII serially.      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module hill_cipher_decrypt #(
    parameter int BLOCK_SIZE = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] key_data,
    input  logic [3:0]            key_addr,
    input  logic                  key_wen,
    input  logic [DATA_WIDTH-1:0] text_in,
    input  logic [1:0]            text_in_addr,
    input  logic                  text_in_wen,
    output logic [DATA_WIDTH-1:0] text_out,
    output logic                  text_out_valid,
    output logic                  done,
    output logic                  busy,
    output logic                  key_err
);

    localparam int c_NKEY = BLOCK_SIZE * BLOCK_SIZE;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DET  = 3'd1,
        S_ADJ  = 3'd2,
        S_MUL  = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    function automatic logic [4:0] f_mod26(input logic [11:0] x);
        return 5'(x % 12'd26);
    endfunction

    // 2x2 determinant a*d - b*c kept non-negative by the 676 offset
    function automatic logic [4:0] f_minor(input logic [4:0] a, input logic [4:0] b,
                                           input logic [4:0] c, input logic [4:0] d);
        return f_mod26(12'(a) * 12'(d) + 12'd676 - 12'(b) * 12'(c));
    endfunction

    function automatic logic [4:0] f_unit_inv(input logic [4:0] x);
        case (x)
            5'd1:    return 5'd1;
            5'd3:    return 5'd9;
            5'd5:    return 5'd21;
            5'd7:    return 5'd15;
            5'd9:    return 5'd3;
            5'd11:   return 5'd19;
            5'd15:   return 5'd7;
            5'd17:   return 5'd23;
            5'd19:   return 5'd11;
            5'd21:   return 5'd5;
            5'd23:   return 5'd17;
            5'd25:   return 5'd25;
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic [1:0] f_lo(input logic [1:0] x);
        return (x == 2'd0) ? 2'd1 : 2'd0;
    endfunction

    function automatic logic [1:0] f_hi(input logic [1:0] x);
        return (x == 2'd2) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [3:0] f_ix(input logic [1:0] r, input logic [1:0] c);
        return 4'(r) * 4'd3 + 4'(c);
    endfunction

    state_t                r_state;
    logic [3:0]            r_idx;
    logic [DATA_WIDTH-1:0] r_key_stage [c_NKEY];
    logic [4:0]            r_txt_stage [BLOCK_SIZE];
    logic [4:0]            r_k         [c_NKEY];
    logic [4:0]            r_c         [BLOCK_SIZE];
    logic [4:0]            r_kinv      [c_NKEY];
    logic [4:0]            r_plain     [BLOCK_SIZE];
    logic [4:0]            r_dinv;

    logic [4:0]  w_txt_map;
    logic [4:0]  w_m0, w_m1, w_m2, w_t, w_det;
    logic        w_key_bad;
    logic [1:0]  w_ar, w_ac;
    logic [4:0]  w_minor, w_cof, w_kinv;
    logic [3:0]  w_row;
    logic [11:0] w_acc;

    always_comb begin
        w_txt_map = 5'd0;
        if (text_in >= DATA_WIDTH'(65) && text_in <= DATA_WIDTH'(90))
            w_txt_map = 5'(text_in - DATA_WIDTH'(65));
        else if (text_in >= DATA_WIDTH'(97) && text_in <= DATA_WIDTH'(122))
            w_txt_map = 5'(text_in - DATA_WIDTH'(97));
    end

    assign w_m0      = f_minor(r_k[4], r_k[5], r_k[7], r_k[8]);
    assign w_m1      = f_minor(r_k[3], r_k[5], r_k[6], r_k[8]);
    assign w_m2      = f_minor(r_k[3], r_k[4], r_k[6], r_k[7]);
    assign w_t       = f_mod26(12'(r_k[0]) * 12'(w_m0) + 12'd676 - 12'(r_k[1]) * 12'(w_m1));
    assign w_det     = f_mod26(12'(w_t) + 12'(r_k[2]) * 12'(w_m2));
    assign w_key_bad = ~w_det[0] | (w_det == 5'd13);

    // adj[ar][ac] is the cofactor at (ac, ar): transpose folded into the indexing
    assign w_ar    = 2'(r_idx / 4'd3);
    assign w_ac    = 2'(r_idx % 4'd3);
    assign w_minor = f_minor(r_k[f_ix(f_lo(w_ac), f_lo(w_ar))], r_k[f_ix(f_lo(w_ac), f_hi(w_ar))],
                             r_k[f_ix(f_hi(w_ac), f_lo(w_ar))], r_k[f_ix(f_hi(w_ac), f_hi(w_ar))]);
    assign w_cof   = (w_ar[0] ^ w_ac[0]) ? f_mod26(12'd26 - 12'(w_minor)) : w_minor;
    assign w_kinv  = f_mod26(12'(r_dinv) * 12'(w_cof));

    assign w_row = f_ix(r_idx[1:0], 2'd0);
    assign w_acc = 12'(r_kinv[w_row])        * 12'(r_c[0])
                 + 12'(r_kinv[w_row + 4'd1]) * 12'(r_c[1])
                 + 12'(r_kinv[w_row + 4'd2]) * 12'(r_c[2]);

    always_ff @(posedge clk) begin
        if (key_wen && key_addr < 4'(c_NKEY))
            r_key_stage[key_addr] <= key_data;
        if (text_in_wen && text_in_addr < 2'(BLOCK_SIZE))
            r_txt_stage[text_in_addr] <= w_txt_map;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    for (int i = 0; i < c_NKEY; i++)
                        r_k[i] <= 5'(r_key_stage[i] % DATA_WIDTH'(26));
                    for (int i = 0; i < BLOCK_SIZE; i++)
                        r_c[i] <= r_txt_stage[i];
                end
            end
            S_DET:   r_dinv <= f_unit_inv(w_det);
            S_ADJ:   r_kinv[r_idx] <= w_kinv;
            S_MUL:   r_plain[r_idx[1:0]] <= f_mod26(w_acc);
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_idx          <= 4'd0;
            text_out       <= '0;
            text_out_valid <= 1'b0;
            done           <= 1'b0;
            busy           <= 1'b0;
            key_err        <= 1'b0;
        end else begin
            text_out_valid <= 1'b0;
            done           <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        key_err <= 1'b0;
                        r_state <= S_DET;
                    end
                end
                S_DET: begin
                    r_idx <= 4'd0;
                    if (w_key_bad) begin
                        key_err <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_ADJ;
                    end
                end
                S_ADJ: begin
                    if (r_idx == 4'(c_NKEY - 1)) begin
                        r_idx   <= 4'd0;
                        r_state <= S_MUL;
                    end else begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                S_MUL: begin
                    if (r_idx == 4'(BLOCK_SIZE - 1)) begin
                        r_idx   <= 4'd0;
                        r_state <= S_OUT;
                    end else begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                S_OUT: begin
                    text_out       <= DATA_WIDTH'(65) + DATA_WIDTH'(r_plain[r_idx[1:0]]);
                    text_out_valid <= 1'b1;
                    if (r_idx == 4'(BLOCK_SIZE - 1)) begin
                        r_idx   <= 4'd0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hill_cipher_decrypt.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hill_cipher_decrypt : directed and random blocks checked against a    |
// | brute-force modular model (searches P with K*P == C mod 26).             |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_hill_cipher_decrypt;

    logic       clk = 1'b0;
    logic       rst, start, key_wen, text_in_wen;
    logic [7:0] key_data, text_in, text_out;
    logic [3:0] key_addr;
    logic [1:0] text_in_addr;
    logic       text_out_valid, done, busy, key_err;

    int          n_total = 0;
    int          n_bad   = 0;
    int          m_key [9];
    byte unsigned m_txt [3];
    bit          exp_err;
    int          exp_p [3];

    always #5 clk = ~clk;

    hill_cipher_decrypt #(.BLOCK_SIZE(3), .DATA_WIDTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .key_data       (key_data),
        .key_addr       (key_addr),
        .key_wen        (key_wen),
        .text_in        (text_in),
        .text_in_addr   (text_in_addr),
        .text_in_wen    (text_in_wen),
        .text_out       (text_out),
        .text_out_valid (text_out_valid),
        .done           (done),
        .busy           (busy),
        .key_err        (key_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int cmap(input byte unsigned ch);
        if (ch >= 65 && ch <= 90)  return int'(ch) - 65;
        if (ch >= 97 && ch <= 122) return int'(ch) - 97;
        return 0;
    endfunction

    // Invertibility from the integer determinant; plaintext by exhaustive search.
    task automatic model();
        int k [9];
        int c [3];
        int det;
        for (int i = 0; i < 9; i++) k[i] = m_key[i] % 26;
        for (int i = 0; i < 3; i++) c[i] = cmap(m_txt[i]);
        det = k[0] * (k[4] * k[8] - k[5] * k[7])
            - k[1] * (k[3] * k[8] - k[5] * k[6])
            + k[2] * (k[3] * k[7] - k[4] * k[6]);
        det = ((det % 26) + 26) % 26;
        exp_err = (det % 2 == 0) || (det == 13);
        exp_p = '{0, 0, 0};
        if (!exp_err) begin
            for (int a = 0; a < 26; a++)
                for (int b = 0; b < 26; b++)
                    for (int d = 0; d < 26; d++)
                        if ((k[0] * a + k[1] * b + k[2] * d) % 26 == c[0] &&
                            (k[3] * a + k[4] * b + k[5] * d) % 26 == c[1] &&
                            (k[6] * a + k[7] * b + k[8] * d) % 26 == c[2])
                            exp_p = '{a, b, d};
        end
    endtask

    task automatic write_key(input int k0, input int k1, input int k2, input int k3,
                             input int k4, input int k5, input int k6, input int k7,
                             input int k8);
        m_key = '{k0, k1, k2, k3, k4, k5, k6, k7, k8};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            key_wen  = 1'b1;
            key_addr = 4'(i);
            key_data = 8'(m_key[i]);
        end
        @(negedge clk);
        key_addr = 4'd11;
        key_data = 8'd7;
        @(negedge clk);
        key_wen = 1'b0;
    endtask

    task automatic write_text(input byte unsigned a, input byte unsigned b, input byte unsigned c);
        m_txt = '{a, b, c};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            text_in_wen  = 1'b1;
            text_in_addr = 2'(i);
            text_in      = m_txt[i];
        end
        @(negedge clk);
        text_in_addr = 2'd3;
        text_in      = 8'h51;
        @(negedge clk);
        text_in_wen = 1'b0;
    endtask

    // One operation from the start edge (edge 0) through edge 16; poke pulses start on that edge.
    task automatic run_block(input string exp_s, input int poke);
        logic [7:0] e [3];
        model();
        for (int i = 0; i < 3; i++)
            e[i] = (exp_s.len() == 3) ? exp_s[i] : 8'(65 + exp_p[i]);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("busy_e0",   32'(busy),    32'd1);
        chk("keyerr_e0", 32'(key_err), 32'd0);
        chk("done_e0",   32'(done),    32'd0);
        for (int ed = 1; ed <= 16; ed++) begin
            @(negedge clk);
            start = (ed == poke);
            @(posedge clk);
            #1;
            if (exp_err) begin
                chk("err_keyerr", 32'(key_err),        32'd1);
                chk("err_done",   32'(done),           32'd1);
                chk("err_busy",   32'(busy),           32'd0);
                chk("err_valid",  32'(text_out_valid), 32'd0);
                break;
            end
            chk("valid", 32'(text_out_valid), 32'(ed >= 14));
            if (ed >= 14) chk("char", 32'(text_out), 32'(e[ed - 14]));
            chk("done", 32'(done), 32'(ed == 16));
            chk("busy", 32'(busy), 32'(ed != 16));
        end
    endtask

    task automatic quiet_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk(tag, {30'd0, done, text_out_valid}, 32'd0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        byte unsigned tc [3];
        rst = 1'b1; start = 1'b0; key_wen = 1'b0; text_in_wen = 1'b0;
        key_data = 8'd0; key_addr = 4'd0; text_in = 8'd0; text_in_addr = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out",   32'(text_out),       32'd0);
        chk("rst_valid", 32'(text_out_valid), 32'd0);
        chk("rst_done",  32'(done),           32'd0);
        chk("rst_busy",  32'(busy),           32'd0);
        chk("rst_err",   32'(key_err),        32'd0);
        @(negedge clk);
        rst = 1'b0;

        write_key(6, 24, 1, 13, 16, 10, 20, 17, 15);
        write_text("P", "O", "H");
        run_block("ACT", 0);
        write_text("F", "I", "N");
        run_block("CAT", 0);
        run_block("CAT", 0);
        write_text("p", "o", "h");
        run_block("ACT", 0);
        write_text("P", "?", "H");
        run_block("", 0);

        write_key(2, 0, 0, 0, 2, 0, 0, 0, 2);
        run_block("", 0);
        chk("model_err", 32'(exp_err), 32'd1);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("err_hold", 32'(key_err), 32'd1);
        end

        write_key(1, 0, 0, 0, 1, 0, 0, 0, 1);
        write_text("X", "Y", "Z");
        fork
            run_block("XYZ", 0);
            begin
                repeat (3) @(negedge clk);
                write_text("A", "B", "C");
            end
        join
        run_block("ABC", 0);

        // abort in ADJ
        write_key(6, 24, 1, 13, 16, 10, 20, 17, 15);
        write_text("P", "O", "H");
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy",  32'(busy),           32'd0);
        chk("abort_valid", 32'(text_out_valid), 32'd0);
        chk("abort_out",   32'(text_out),       32'd0);
        chk("abort_done",  32'(done),           32'd0);
        @(negedge clk);
        rst = 1'b0;
        quiet_cycles(20, "abort_quiet");
        run_block("ACT", 0);

        run_block("ACT", 12);
        quiet_cycles(20, "ignored_start");

        for (int t = 0; t < 10; t++) begin
            write_key(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 255)));
            for (int i = 0; i < 3; i++) begin
                case ($urandom_range(0, 3))
                    0:       tc[i] = 8'(65 + $urandom_range(0, 25));
                    1:       tc[i] = 8'(97 + $urandom_range(0, 25));
                    default: tc[i] = 8'($urandom_range(32, 126));
                endcase
            end
            write_text(tc[0], tc[1], tc[2]);
            run_block("", 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hill_cipher_decrypt.md
Name: hill_cipher_decrypt

Overview:
- Inverse of the team's Hill cipher encryption block: recovers P = K^-1 · C (mod 26) for a 3-letter ciphertext block, using the same 3x3 key that encrypted it.
- Computes det(K) mod 26, its modular inverse and the adjugate internally, then performs the 3x3 by 3x1 product with a local multiply-accumulate datapath.
- Sits beside the encryptor in the crypto path. Shares its key and text write-port style, and produces the same serialized ASCII output stream.

Parameters:
- BLOCK_SIZE, 3, vector length. Only 3 is supported; the cofactor logic is fixed at 3x3.
- DATA_WIDTH, 8, width of key entries and of the external characters (ASCII).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin decryption of the staged block. Sampled only in IDLE.
- key_data  input  DATA_WIDTH  key entry, numeric 0..255, reduced mod 26 internally
- key_addr  input  4  key index 0..8, row-major (addr = row*3+col)
- key_wen  input  1  write enable for the key staging array
- text_in  input  DATA_WIDTH  ciphertext character (ASCII)
- text_in_addr  input  2  ciphertext index 0..2
- text_in_wen  input  1  write enable for the ciphertext staging array
- text_out  output  DATA_WIDTH  plaintext character, uppercase ASCII
- text_out_valid  output  1  one-cycle qualifier per text_out character
- done  output  1  one-cycle pulse at the end of every operation, success or error
- busy  output  1  high from the start acceptance edge until the edge that raises done
- key_err  output  1  key is not invertible mod 26. Held until the next accepted start or reset.

Behaviour:
- Reset (asynchronous): state=IDLE; text_out=0, text_out_valid=0, done=0, busy=0, key_err=0.
  - Staging arrays are not cleared.
  - Addresses outside 0..8 for the key or 0..2 for text are ignored.
- Staging writes:
  - Writes are accepted every cycle, including while busy.
  - Ciphertext is mapped at write time: 'A'-'Z' -> 0..25, 'a'-'z' -> 0..25, any other character -> 0.
- Snapshot: on the edge that accepts start, the 9 key entries (each mod 26) and 3 text values are copied into working registers.
  - Staging writes made after that edge do not affect the current operation.
- State machine: IDLE -> DET -> ADJ -> MUL -> OUT -> IDLE.
  - Edge 0 (start seen in IDLE): snapshot taken, busy=1, key_err=0, state=DET.
  - DET, 1 cycle:
    - d = det(K) mod 26, computed with non-negative offset arithmetic (add 676 before each subtraction; no signed wrap).
    - dinv comes from a constant table of units mod 26: 1->1, 3->9, 5->21, 7->15, 9->3, 11->19, 15->7, 17->23, 19->11, 21->5, 23->17, 25->25.
    - If d is even or d==13, this edge sets key_err=1, done=1, busy=0 and returns to IDLE. No text_out_valid is raised.
  - ADJ, 9 cycles, index i=0..8:
    - Kinv[i] = (dinv · adj[i]) mod 26, where adj = transpose of the cofactor matrix.
    - Each cofactor is (a·d + 676 - b·c) mod 26, with the sign applied as (26 - x) mod 26.
  - MUL, 3 cycles, row r=0..2: P[r] = (Kinv[r,0]·C0 + Kinv[r,1]·C1 + Kinv[r,2]·C2) mod 26.
    - Worst-case sum is 3·625 = 1875; accumulator is at least 11 bits.
  - OUT, 3 cycles:
    - text_out = 'A' + P[k] for k=0,1,2 on consecutive cycles, with text_out_valid=1 each cycle.
    - done=1 and busy=0 are set on the same edge as the third character; state returns to IDLE.
- Latency on success: the three characters are registered on edges 14, 15 and 16 after edge 0. On a key error, done is registered on edge 1.
- text_out holds its last value when text_out_valid=0.
- start while busy is ignored and not queued. start held high re-triggers on the first IDLE cycle after done.
- Reset mid-operation aborts immediately with no done. A subsequent start uses fresh snapshots.

Test Plan:
- Valid key: key GYBNQKURP = {6,24,1,13,16,10,20,17,15}, text "POH", start.
  - Required: d=25, no key_err.
  - text_out "A","C","T" with valid on edges 14–16; done coincident with "T"; busy low after.
- Same key, text "FIN" -> "CAT". Back-to-back start one cycle after done is accepted and produces a second correct block.
- Lowercase and non-letter input:
  - Text "poh" -> "ACT".
  - Text "P?H" maps '?' to 0 and decrypts "P","A","H" per the formula (check against the model).
- Invalid key: {2,0,0,0,2,0,0,0,2} (d=8).
  - Required: key_err=1 and done pulse on edge 1, no text_out_valid, busy low.
  - A following start with a valid key clears key_err.
- Identity key {1,0,0,0,1,0,0,0,1}:
  - Text "XYZ" -> "XYZ".
  - Rewriting text to "ABC" during busy does not change that output.
  - The next start yields "ABC".
- Abort and ignored start:
  - Assert rst during ADJ -> all outputs 0, no done; a later start completes normally.
  - A start asserted during MUL is ignored, giving exactly three valid characters.
